// File: rtl/serial_subtractor_8.sv
// Bit-serial subtractor: d = a - b, one bit per clock, LSB first.
// Single full-subtractor cell, borrow flop and WIDTH-step bit counter.
module serial_subtractor_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    logic             diff_bit;
    logic             br_next;

    assign diff_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next  = (~sa_q[0] & sb_q[0]) |
                      (~(sa_q[0] ^ sb_q[0]) & br_q);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = {diff_bit, sr_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the result including this edge's bit
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d      = {diff_bit, sr_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign d      = d_q;
    assign borrow = borrow_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;

endmodule
